pll_lock_sequencer: RTL and testbench

Supervises the ECP5 PLL that generates the miner core clock. Runs on the always-on 12 MHz board clock and drives the PLL reset and standby pins, including reset pulses. Qualifies the PLL lock output, retries or faults on lock timeout, and holds the mining core in reset until the PLL clock is stable. The core_reset output is consumed by a reset synchroniser in the PLL clock domain; that synchroniser is outside this block.

---
 rtl/pll_lock_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// Supervises the core-clock PLL: reset/standby sequencing, lock qualification, retry and fault.
// Optional lock-loss counter enabled by defining PLL_LOCK_LOSS_COUNT_EN.
module pll_lock_sequencer #(
  parameter int unsigned PLL_RESET_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT     = 12000,
  parameter int unsigned STABLE_CYCLES    = 1200,
  parameter int unsigned MAX_RETRIES      = 3,
  parameter int unsigned COUNT_W          = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       pll_locked,
  output logic       pll_reset,
  output logic       pll_standby,
  output logic       core_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  typedef enum logic [2:0] {
    S_OFF, S_RESET_PLL, S_WAIT_LOCK, S_STABILIZE, S_RUN, S_FAULT
  } state_t;

  localparam logic [COUNT_W-1:0] RESET_LAST   = COUNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [COUNT_W-1:0] TIMEOUT_LAST = COUNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [COUNT_W-1:0] STABLE_LAST  = COUNT_W'(STABLE_CYCLES - 1);

  state_t             state, state_nxt;
  logic [COUNT_W-1:0] timer, timer_nxt;
  logic [3:0]         retry_nxt;
  logic               fault_nxt;
  logic               lock_meta, lock_s;
  logic               pll_reset_nxt, pll_standby_nxt, core_reset_nxt, ready_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_count;
    fault_nxt = fault;
    if (!enable) begin
      state_nxt = S_OFF;
    end else begin
      case (state)
        S_OFF: begin
          state_nxt = S_RESET_PLL;
          retry_nxt = '0;
          fault_nxt = 1'b0;
        end
        S_RESET_PLL: begin
          if (timer == RESET_LAST) state_nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt = S_STABILIZE;
          end else if (timer == TIMEOUT_LAST) begin
            if (32'(retry_count) == MAX_RETRIES) begin
              state_nxt = S_FAULT;
              fault_nxt = 1'b1;
            end else begin
              state_nxt = S_RESET_PLL;
              retry_nxt = (retry_count == 4'hF) ? 4'hF : retry_count + 4'd1;
            end
          end
        end
        S_STABILIZE: begin
          if (!lock_s) begin
            state_nxt = S_WAIT_LOCK;
          end else if (timer == STABLE_LAST) begin
            state_nxt = S_RUN;
            retry_nxt = '0;
          end
        end
        S_RUN: begin
          if (!lock_s) state_nxt = S_WAIT_LOCK;
        end
        S_FAULT: begin
          state_nxt = S_FAULT;
        end
        default: begin
          state_nxt = S_OFF;
        end
      endcase
    end
  end

  // Timer is cleared on every state change and only runs in the timed states,
  // so its terminal compares are always reached before it could wrap.
  always_comb begin
    timer_nxt = '0;
    if (state_nxt == state &&
        (state == S_RESET_PLL || state == S_WAIT_LOCK || state == S_STABILIZE))
      timer_nxt = timer + 1'b1;
  end

  // Outputs decode the next state so they register on the same edge as the state.
  always_comb begin
    pll_reset_nxt   = 1'b1;
    pll_standby_nxt = 1'b1;
    core_reset_nxt  = 1'b1;
    ready_nxt       = 1'b0;
    case (state_nxt)
      S_RESET_PLL: begin
        pll_standby_nxt = 1'b0;
      end
      S_WAIT_LOCK, S_STABILIZE: begin
        pll_standby_nxt = 1'b0;
        pll_reset_nxt   = 1'b0;
      end
      S_RUN: begin
        pll_standby_nxt = 1'b0;
        pll_reset_nxt   = 1'b0;
        core_reset_nxt  = 1'b0;
        ready_nxt       = 1'b1;
      end
      default: begin
        pll_reset_nxt   = 1'b1;
        pll_standby_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_OFF;
      timer       <= '0;
      retry_count <= '0;
      fault       <= 1'b0;
      pll_reset   <= 1'b1;
      pll_standby <= 1'b1;
      core_reset  <= 1'b1;
      ready       <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      retry_count <= retry_nxt;
      fault       <= fault_nxt;
      pll_reset   <= pll_reset_nxt;
      pll_standby <= pll_standby_nxt;
      core_reset  <= core_reset_nxt;
      ready       <= ready_nxt;
    end
  end

`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [7:0] loss_cnt;

  // Counts only lock-driven exits from RUN; enable=0 takes priority and is not a loss.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      loss_cnt <= '0;
    else if (enable && state == S_RUN && !lock_s && loss_cnt != 8'hFF)
      loss_cnt <= loss_cnt + 8'd1;
  end

  assign lock_loss_count = loss_cnt;
`else
  assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: cycle-stamped expectations checked by a negedge monitor.
module tb_pll_lock_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       pll_locked = 1'b1;
  logic       pll_reset, pll_standby, core_reset, ready, fault;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  pll_lock_sequencer #(
    .PLL_RESET_CYCLES(4),
    .LOCK_TIMEOUT(20),
    .STABLE_CYCLES(8),
    .MAX_RETRIES(2),
    .COUNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .pll_locked(pll_locked),
    .pll_reset(pll_reset),
    .pll_standby(pll_standby),
    .core_reset(core_reset),
    .ready(ready),
    .fault(fault),
    .retry_count(retry_count),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [16:0] mask;
    logic [16:0] val;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [7:0]  llc_one;
  logic [16:0] obs;

  assign obs = {pll_reset, pll_standby, core_reset, ready, fault, retry_count, lock_loss_count};

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [16:0] vec(logic pr, logic ps, logic cr, logic rd, logic ft,
                                      logic [3:0] rc, logic [7:0] llc);
    return {pr, ps, cr, rd, ft, rc, llc};
  endfunction

  function automatic logic [16:0] off_v(logic ft, logic [3:0] rc, logic [7:0] llc);
    return vec(1'b1, 1'b1, 1'b1, 1'b0, ft, rc, llc);
  endfunction
  function automatic logic [16:0] rst_v(logic [3:0] rc, logic [7:0] llc);
    return vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, rc, llc);
  endfunction
  function automatic logic [16:0] wait_v(logic [3:0] rc, logic [7:0] llc);
    return vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rc, llc);
  endfunction
  function automatic logic [16:0] run_v(logic [7:0] llc);
    return vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, llc);
  endfunction
  function automatic logic [16:0] fault_v(logic [3:0] rc, logic [7:0] llc);
    return vec(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, rc, llc);
  endfunction

  task automatic push(input int unsigned off, input string name, input logic [16:0] val,
                      input logic [16:0] mask = '1);
    exp_t n;
    int   idx;
    n.cyc  = cyc + off;
    n.name = name;
    n.mask = mask;
    n.val  = val;
    idx = q.size();
    while (idx > 0 && q[idx-1].cyc > n.cyc) idx--;
    q.insert(idx, n);
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: missed at cycle %0d (now %0d)", e.name, e.cyc, cyc);
      end else if ((obs & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL %s @%0d: got %05h required %05h (mask %05h)",
                 e.name, cyc, obs, e.val, e.mask);
      end
    end
  end

  initial begin
`ifdef PLL_LOCK_LOSS_COUNT_EN
    llc_one = 8'd1;
`else
    llc_one = 8'd0;
`endif
    // Reset state and clean lock
    wait_cyc(2);
    push(0, "reset_state", off_v(1'b0, 4'd0, 8'd0));
    reset = 1'b0;
    wait_cyc(3);
    enable = 1'b1;
    push(0,  "clean_off",        off_v(1'b0, 4'd0, 8'd0));
    push(1,  "clean_rst_first",  rst_v(4'd0, 8'd0));
    push(4,  "clean_rst_last",   rst_v(4'd0, 8'd0));
    push(5,  "clean_wait",       wait_v(4'd0, 8'd0));
    push(13, "clean_not_ready",  wait_v(4'd0, 8'd0));
    push(14, "clean_run",        run_v(8'd0));
    wait_cyc(16);

    // Lock loss in RUN
    pll_locked = 1'b0;
    push(2,  "loss_still_run",   run_v(8'd0));
    push(3,  "loss_core_reset",  wait_v(4'd0, llc_one));
    push(13, "loss_relock_hold", wait_v(4'd0, llc_one));
    push(14, "loss_relock_run",  run_v(llc_one));
    wait_cyc(3);
    pll_locked = 1'b1;
    wait_cyc(14);

    // Glitch during STABILIZE
    enable = 1'b0;
    push(1, "disable_off", off_v(1'b0, 4'd0, llc_one));
    wait_cyc(2);
    enable = 1'b1;
    push(13, "glitch_stab",      wait_v(4'd0, llc_one));
    push(14, "glitch_no_early",  wait_v(4'd0, llc_one));
    push(20, "glitch_no_retry",  wait_v(4'd0, llc_one));
    push(23, "glitch_not_ready", wait_v(4'd0, llc_one));
    push(24, "glitch_run",       run_v(llc_one));
    wait_cyc(11);
    pll_locked = 1'b0;
    wait_cyc(2);
    pll_locked = 1'b1;
    wait_cyc(14);

    // Timeout retries into FAULT
    enable = 1'b0;
    pll_locked = 1'b0;
    wait_cyc(3);
    enable = 1'b1;
    push(1,   "to_rst0",     rst_v(4'd0, llc_one));
    push(5,   "to_wait0",    wait_v(4'd0, llc_one));
    push(24,  "to_wait0_end", wait_v(4'd0, llc_one));
    push(25,  "to_retry1",   rst_v(4'd1, llc_one));
    push(29,  "to_wait1",    wait_v(4'd1, llc_one));
    push(48,  "to_wait1_end", wait_v(4'd1, llc_one));
    push(49,  "to_retry2",   rst_v(4'd2, llc_one));
    push(53,  "to_wait2",    wait_v(4'd2, llc_one));
    push(72,  "to_wait2_end", wait_v(4'd2, llc_one));
    push(73,  "to_fault",    fault_v(4'd2, llc_one));
    push(190, "fault_holds", fault_v(4'd2, llc_one));
    wait_cyc(191);

    // Recovery from FAULT
    enable = 1'b0;
    pll_locked = 1'b1;
    push(1, "rec_off", off_v(1'b0, 4'd0, llc_one), 17'h1E0FF);
    wait_cyc(1);
    enable = 1'b1;
    push(1,  "rec_rst_clear", rst_v(4'd0, llc_one));
    push(13, "rec_not_ready", wait_v(4'd0, llc_one));
    push(14, "rec_run",       run_v(llc_one));
    wait_cyc(16);

    // Asynchronous reset between edges
    push(0, "async_reset", off_v(1'b0, 4'd0, 8'd0));
    #1;
    reset = 1'b1;
    push(2, "reset_hold", off_v(1'b0, 4'd0, 8'd0));
    wait_cyc(3);

    for (int i = 0; i < 50 && q.size() > 0; i++) wait_cyc(1);
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never checked, expected at cycle %0d", e.name, e.cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
